// File: rtl/i2c_master_tx.sv
// i2c_master_tx: write-only I2C master sending START, {ADDRESS,W}, WRITE_LENGTH bytes, STOP.
// Latency: done pulses (2 + 9*(1+WRITE_LENGTH))*CLK_PER_BIT cycles after start is accepted.
// Backpressure: start is taken only in IDLE and ignored while busy; fixed bus timing, no clock stretching.
module i2c_master_tx #(
    parameter int         CLK_PER_BIT  = 1000,
    parameter logic [6:0] ADDRESS      = 7'b1100100,
    parameter int         WRITE_LENGTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [8*WRITE_LENGTH-1:0] tx_data,
    output logic                      busy,
    output logic                      done,
    output logic                      ack_error,
    output logic                      SCL,
    inout  wire                       SDA
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int BW = (WRITE_LENGTH > 1) ? $clog2(WRITE_LENGTH) : 1;

    // Quarter-period landmarks of one bit period.
    localparam logic [CW-1:0] Q1_CNT     = CW'(CLK_PER_BIT / 4);
    localparam logic [CW-1:0] Q2_CNT     = CW'(CLK_PER_BIT / 2);
    localparam logic [CW-1:0] Q3_CNT     = CW'((3 * CLK_PER_BIT) / 4);
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BYTE  = BW'(WRITE_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP
    } state_t;

    state_t                      state;
    logic [CW-1:0]               cnt;
    logic [2:0]                  bit_cnt;
    logic [BW-1:0]               byte_cnt;
    logic [8*WRITE_LENGTH-1:0]   shift_reg;
    logic [7:0]                  addr_byte;
    logic [1:0]                  sda_sync;
    logic                        sda_low;
    logic                        scl_nxt;
    logic                        sda_low_nxt;
    logic                        std_scl;
    logic                        wrap;
    logic [7:0]                  cur_byte;

    // Open-drain pad: only ever pull low, otherwise release to the pull-up.
    assign SDA      = sda_low ? 1'b0 : 1'bz;
    assign cur_byte = shift_reg[8*WRITE_LENGTH-1 -: 8];
    assign wrap     = (cnt == LAST_CNT);
    assign std_scl  = (cnt >= Q1_CNT) && (cnt < Q3_CNT);

    // Bus pin levels for the current state and position within the bit period.
    always_comb begin
        scl_nxt     = 1'b1;
        sda_low_nxt = 1'b0;
        case (state)
            IDLE: begin
                scl_nxt     = 1'b1;
                sda_low_nxt = 1'b0;
            end
            START: begin
                scl_nxt     = (cnt < Q2_CNT);
                sda_low_nxt = 1'b1;
            end
            ADDR: begin
                scl_nxt     = std_scl;
                sda_low_nxt = ~addr_byte[3'd7 - bit_cnt];
            end
            DATA: begin
                scl_nxt     = std_scl;
                sda_low_nxt = ~cur_byte[3'd7 - bit_cnt];
            end
            ADDR_ACK, DATA_ACK: begin
                scl_nxt     = std_scl;
                sda_low_nxt = 1'b0;
            end
            STOP: begin
                // SCL rises at Q, SDA released at 2Q while SCL is high.
                scl_nxt     = (cnt >= Q1_CNT);
                sda_low_nxt = (cnt < Q2_CNT);
            end
            default: begin
                scl_nxt     = 1'b1;
                sda_low_nxt = 1'b0;
            end
        endcase
    end

    // Transaction sequencer: counters, shift data, ACK sampling and registered pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift_reg <= '0;
            addr_byte <= '0;
            sda_sync  <= 2'b11;
            sda_low   <= 1'b0;
            SCL       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
        end else begin
            sda_sync <= {sda_sync[0], SDA};
            SCL      <= scl_nxt;
            sda_low  <= sda_low_nxt;
            done     <= 1'b0;

            if (state == IDLE) begin
                cnt      <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                if (start) begin
                    shift_reg <= tx_data;
                    addr_byte <= {ADDRESS, 1'b0};
                    ack_error <= 1'b0;
                    busy      <= 1'b1;
                    state     <= START;
                end
            end else begin
                cnt <= wrap ? '0 : cnt + 1'b1;

                case (state)
                    START: begin
                        if (wrap) begin
                            state <= ADDR;
                        end
                    end
                    ADDR: begin
                        if (wrap) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state <= ADDR_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if ((cnt == SAMPLE_CNT) && sda_sync[1]) begin
                            ack_error <= 1'b1;
                        end
                        // ack_error was cleared at accept, so here it reflects only this ACK.
                        if (wrap) begin
                            state <= ack_error ? STOP : DATA;
                        end
                    end
                    DATA: begin
                        if (wrap) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state <= DATA_ACK;
                            end
                        end
                    end
                    DATA_ACK: begin
                        // The slave NACKs the final byte by design, so that sample is ignored.
                        if ((cnt == SAMPLE_CNT) && sda_sync[1] && (byte_cnt != LAST_BYTE)) begin
                            ack_error <= 1'b1;
                        end
                        if (wrap) begin
                            if ((byte_cnt == LAST_BYTE) || ack_error) begin
                                state <= STOP;
                            end else begin
                                shift_reg <= shift_reg << 8;
                                byte_cnt  <= byte_cnt + 1'b1;
                                state     <= DATA;
                            end
                        end
                    end
                    STOP: begin
                        if (wrap) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: behavioural I2C slave on the bus plus a transaction-level
// model predicting latency, ack_error, slave register contents and SCL pulse counts.
// Short bit period keeps every scenario to a few thousand cycles.
module tb_i2c_master_tx;

    localparam int         CPB  = 40;
    localparam int         WL   = 2;
    localparam logic [6:0] ADDR = 7'h64;
    localparam int         LAT  = (2 + 9 * (1 + WL)) * CPB;

    logic              clk;
    logic              reset = 1'b1;
    logic              start;
    logic [8*WL-1:0]   tx_data;
    logic              busy;
    logic              done;
    logic              ack_error;
    logic              SCL;
    wire               sda_bus;

    int tests = 0;
    int fails = 0;

    i2c_master_tx #(
        .CLK_PER_BIT (CPB),
        .ADDRESS     (ADDR),
        .WRITE_LENGTH(WL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done),
        .ack_error(ack_error),
        .SCL      (SCL),
        .SDA      (sda_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural slave ----------------
    logic            slave_low = 1'b0;
    logic [6:0]      slave_addr = ADDR;
    int              n_ack = WL - 1;
    bit              in_frame = 1'b0;
    bit              matched = 1'b0;
    int              bitn = 0;
    int              byte_idx = 0;
    logic [7:0]      shreg = 8'h00;
    logic [7:0]      addr_seen = 8'h00;
    logic [8*WL-1:0] shadow = '0;
    logic [8*WL-1:0] led_data = '0;
    int              scl_rises = 0;

    pullup (sda_bus);
    assign sda_bus = slave_low ? 1'b0 : 1'bz;

    // START condition: SDA falls while SCL high.
    always @(negedge sda_bus) begin
        if (SCL === 1'b1) begin
            in_frame  = 1'b1;
            matched   = 1'b0;
            bitn      = 0;
            byte_idx  = 0;
            slave_low = 1'b0;
        end
    end

    // STOP condition: SDA rises while SCL high; commit only a complete write.
    always @(posedge sda_bus) begin
        if ((SCL === 1'b1) && in_frame) begin
            in_frame = 1'b0;
            if (matched && (byte_idx == WL + 1)) led_data = shadow;
        end
    end

    // Sample data on SCL rising edges.
    always @(posedge SCL) begin
        scl_rises++;
        if (in_frame) begin
            if (bitn < 8) shreg = {shreg[6:0], (sda_bus === 1'b0) ? 1'b0 : 1'b1};
            bitn++;
        end
    end

    // Drive/release ACK on SCL falling edges.
    always @(negedge SCL) begin
        if (in_frame) begin
            if (bitn == 8) begin
                if (byte_idx == 0) begin
                    addr_seen = shreg;
                    matched   = (shreg == {slave_addr, 1'b0});
                    slave_low = matched;
                end else begin
                    shadow    = {shadow[8*WL-9:0], shreg};
                    slave_low = ((byte_idx - 1) < n_ack);
                end
                byte_idx++;
            end else if (bitn == 9) begin
                slave_low = 1'b0;
                bitn      = 0;
                if (!matched) in_frame = 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int              done_q[$];
    logic [8*WL-1:0] led_q[$];
    int              busy_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one accepted start and watch a bounded window of cycles after it.
    task automatic run(input logic [8*WL-1:0] d0, input logic [8*WL-1:0] d1,
                       input int pulse_at, input bit hold, input int window);
        done_q.delete();
        led_q.delete();
        busy_err = 0;
        @(negedge clk);
        tx_data = d0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        scl_rises = 0;
        if (!hold) start = 1'b0;
        tx_data = d1;
        for (int k = 1; k <= window; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                done_q.push_back(k);
                led_q.push_back(led_data);
            end
            if ((done_q.size() == 0) && (busy !== 1'b1)) busy_err++;
            if (k == pulse_at) start = 1'b1;
            else if (!hold) start = 1'b0;
            if (hold && (done_q.size() > 0) && (k >= done_q[0] + 1)) start = 1'b0;
        end
        start = 1'b0;
    endtask

    // Model the outcome from the slave configuration, run, and compare.
    task automatic scenario(input string tag, input logic [8*WL-1:0] d, input bit pulse);
        bit              addr_ok;
        int              nbytes;
        int              exp_lat;
        logic            exp_err;
        logic [8*WL-1:0] exp_led;
        int              pulse_at;
        int              first;
        logic [8*WL-1:0] led_first;
        addr_ok  = (slave_addr == ADDR);
        nbytes   = !addr_ok ? 0 : ((n_ack + 1 < WL) ? n_ack + 1 : WL);
        exp_lat  = (2 + 9 * (1 + nbytes)) * CPB;
        exp_err  = !addr_ok || (nbytes < WL);
        exp_led  = (addr_ok && nbytes == WL) ? d : led_data;
        pulse_at = pulse ? int'($urandom_range(exp_lat - 2 * CPB, CPB)) : -1;
        run(d, 16'($urandom), pulse_at, 1'b0, exp_lat + 2 * CPB);
        first     = (done_q.size() > 0) ? done_q[0] : -1;
        led_first = (led_q.size() > 0) ? led_q[0] : ~exp_led;
        check({tag, "_done_count"}, done_q.size(), 1);
        check({tag, "_latency"}, first, exp_lat);
        check({tag, "_busy_window"}, busy_err, 0);
        check({tag, "_ack_error"}, ack_error, exp_err);
        check({tag, "_led_data"}, led_first, exp_led);
        check({tag, "_scl_pulses"}, scl_rises, 9 * (1 + nbytes) + 1);
        check({tag, "_addr_byte"}, addr_seen, {ADDR, 1'b0});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int r;
        start   = 1'b0;
        tx_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_scl", SCL, 1'b1);
        check("reset_sda", sda_bus, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ack_error", ack_error, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        scenario("write_a55a", 16'hA55A, 1'b0);
        scenario("rand_write0", 16'($urandom), 1'b0);
        scenario("rand_write1", 16'($urandom), 1'b0);

        slave_addr = 7'h10;
        scenario("addr_nack", 16'($urandom), 1'b0);
        slave_addr = ADDR;

        n_ack = 0;
        scenario("data_nack", 16'($urandom), 1'b0);
        n_ack = WL - 1;

        scenario("after_error", 16'($urandom), 1'b0);
        scenario("start_while_busy", 16'($urandom), 1'b1);

        // start held high across two transactions
        run(16'h1234, 16'hFFFF, -1, 1'b1, 2 * LAT + 1 + 2 * CPB);
        check("b2b_done_count", done_q.size(), 2);
        check("b2b_first_latency", (done_q.size() > 0) ? done_q[0] : -1, LAT);
        check("b2b_gap", (done_q.size() > 1) ? done_q[1] - done_q[0] : -1, LAT + 1);
        check("b2b_led0", (led_q.size() > 0) ? led_q[0] : 16'h0, 16'h1234);
        check("b2b_led1", (led_q.size() > 1) ? led_q[1] : 16'h0, 16'hFFFF);

        // reset in the middle of the first data byte
        @(negedge clk);
        tx_data = 16'($urandom);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r = int'($urandom_range(17 * CPB, 10 * CPB + 2));
        repeat (r) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_scl", SCL, 1'b1);
        check("midreset_sda", sda_bus, 1'b1);
        check("midreset_busy", busy, 1'b0);
        check("midreset_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        scenario("after_reset", 16'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
